deu_gpr_wb_arb: RTL and testbench
=================================

DEU_GPR_WB_ARB -- requirements
Module: deu_gpr_wb_arb

Interface
REQ-001 Parameter: NREQ, default 4, number of writeback requesters, fixed at 4 in this release.
REQ-002 Parameter: NPORT, default 3, number of GPR write ports driven, fixed at 3.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  writeback request per requester.
REQ-006 req_addr  input  NREQ x `LA64_ARF_SEL  destination GPR index per requester.
REQ-007 req_data  input  NREQ x `LA64_DATA_WIDTH  writeback data per requester.
REQ-008 req_ready  output  NREQ  combinational accept; the transfer occurs when valid and ready are both high.
REQ-009 we0..we2  output  1 each  registered GPR write enables.
REQ-010 waddr0..waddr2  output  `LA64_ARF_SEL each  registered GPR write addresses.
REQ-011 wdata0..wdata2  output  `LA64_DATA_WIDTH each  registered GPR write data.

Function
REQ-012 Requester i SHALL hold req_addr[i] and req_data[i] stable while req_valid[i]=1 and req_ready[i]=0.
REQ-013 A valid request with req_addr=0 SHALL be accepted in the same cycle, SHALL consume no port, and SHALL produce no write.
REQ-014 Priority order SHALL be scanned from the current head index upward, modulo NREQ.
REQ-015 Each cycle, the block SHALL grant at most NPORT nonzero-address requests, taken in priority order.
REQ-016 A request whose address equals the address of an already-granted request in the same cycle SHALL NOT be granted that cycle; it SHALL keep waiting.
REQ-017 Granted requests SHALL map to ports 0, 1, 2 in priority order.
REQ-018 weN/waddrN/wdataN SHALL register the grant one cycle after acceptance (latency 1).
REQ-019 An unused port SHALL register we=0, waddr=0, wdata=0.
REQ-020 req_ready[i] SHALL be 1 only in the cycle request i is granted or dropped under REQ-013; it SHALL be 0 when req_valid[i]=0.
REQ-021 No two enabled outputs in the same cycle SHALL carry equal waddr.
REQ-022 Head pointer SHALL be 2 bits, and SHALL update under REQ-030/REQ-031.

Reset
REQ-023 While rst=1, the block SHALL drive we0..we2=0, waddr0..waddr2=0, wdata0..wdata2=0, set head=0, and drive req_ready=0.
REQ-024 Reset asserted mid-stream SHALL discard the registered writes from the prior cycle on the next edge.
REQ-025 A request not accepted before reset SHALL remain the requester's responsibility to re-present.
REQ-026 In the first cycle after rst deasserts, the block SHALL arbitrate normally with head=0.

Configuration
REQ-027 The macro DEU_WB_RR_EN SHALL select the priority scheme.
REQ-028 With DEU_WB_RR_EN defined, priority SHALL be round-robin.
REQ-029 Without DEU_WB_RR_EN, the head pointer SHALL be constant 0, giving fixed priority req0>req1>req2>req3, with no pointer flop present.
REQ-030 Under round-robin, after any cycle with one or more nonzero-address grants, head SHALL become (last granted index in scan order + 1) mod NREQ.
REQ-031 Under round-robin, head SHALL be unchanged in cycles with no such grants.
REQ-032 Under round-robin, every continuously valid requester SHALL be granted within NREQ cycles.

Structure
REQ-033 NREQ, NPORT, and typedef wb_req_t {addr, data} SHALL reside in shared package deu_pkg.
REQ-034 Widths SHALL come from `LA64_ARF_SEL and `LA64_DATA_WIDTH in constants.vh.
REQ-035 Grant selection SHALL live in one sub-module, deu_wb_prio_sel (rotated scan, address-conflict masking, port mapping).
REQ-036 Output registers SHALL use the codebase dffe/dff cells.

Verification
REQ-037 Scenario: all 4 valid, addr 1/2/3/4, data A/B/C/D, head=0 -> ready=0111; next cycle we=111, waddr=1,2,3, wdata=A,B,C; the following cycle req3 wins port 0.
REQ-038 Scenario: req0 and req1 both addr 5 -> only req0 is granted; req1 is granted the next cycle; no cycle shows two enabled ports with waddr=5.
REQ-039 Scenario: req2 addr 0, valid -> ready[2]=1 immediately; no we is asserted for it; port count is unaffected.
REQ-040 Scenario: RR build, all 4 continuously valid with distinct addresses for 8 cycles -> each requester is granted at least once every 2 cycles; head sequence is 0,3,2,1,0...
REQ-041 Scenario: fixed build, same stimulus as REQ-040 -> req3 is never granted while req0..req2 stay valid.
REQ-042 Scenario: rst=1 raised the cycle after grants -> next edge gives we=000, waddr=0, wdata=0, head=0; no ready is asserted during reset.

Source files
------------

// File: rtl/deu_pkg.sv
// +--------------------------------------------------------------------------+
// | deu_pkg : shared writeback-arbiter constants and request type            |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef LA64_ARF_SEL
`define LA64_ARF_SEL 5
`endif
`ifndef LA64_DATA_WIDTH
`define LA64_DATA_WIDTH 64
`endif

package deu_pkg;
  localparam int NREQ   = 4;
  localparam int NPORT  = 3;
  localparam int HEAD_W = 2;

  typedef struct packed {
    logic [`LA64_ARF_SEL-1:0]    addr;
    logic [`LA64_DATA_WIDTH-1:0] data;
  } wb_req_t;
endpackage

`default_nettype wire

// File: rtl/deu_dff.sv
// +--------------------------------------------------------------------------+
// | dff / dffe : codebase flop cells, synchronous active-high reset to zero  |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end
endmodule

module dffe #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end
endmodule

`default_nettype wire

// File: rtl/deu_wb_prio_sel.sv
// +--------------------------------------------------------------------------+
// | deu_wb_prio_sel : rotated priority scan, address-conflict masking, port  |
// | mapping for the GPR writeback arbiter.  Rev 1.0 : initial release        |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef LA64_ARF_SEL
`define LA64_ARF_SEL 5
`endif
`ifndef LA64_DATA_WIDTH
`define LA64_DATA_WIDTH 64
`endif

module deu_wb_prio_sel #(
  parameter int NREQ   = deu_pkg::NREQ,
  parameter int NPORT  = deu_pkg::NPORT,
  parameter int HEAD_W = deu_pkg::HEAD_W
) (
  input  logic [HEAD_W-1:0]                          head,
  input  logic [NREQ-1:0]                            valid,
  input  logic [NREQ-1:0][`LA64_ARF_SEL-1:0]         addr,
  input  logic [NREQ-1:0][`LA64_DATA_WIDTH-1:0]      data,
  output logic [NREQ-1:0]                            accept,
  output logic [NPORT-1:0]                           port_en,
  output deu_pkg::wb_req_t [NPORT-1:0]               port_req,
  output logic                                       any_grant,
  output logic [HEAD_W-1:0]                          next_head
);
  import deu_pkg::*;

  localparam logic [2:0] PORT_CNT = 3'(NPORT);

  logic [HEAD_W-1:0] idx;
  logic [2:0]        used;
  logic              conflict;

  always_comb begin
    accept    = '0;
    port_en   = '0;
    port_req  = '0;
    any_grant = 1'b0;
    next_head = head;
    used      = '0;
    idx       = '0;
    conflict  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx      = head + HEAD_W'(k);
      conflict = 1'b0;
      // Only requests already granted this cycle block a matching address.
      for (int p = 0; p < NPORT; p++) begin
        if (port_en[p] && (port_req[p].addr == addr[idx])) conflict = 1'b1;
      end
      if (valid[idx]) begin
        if (addr[idx] == '0) begin
          accept[idx] = 1'b1;
        end else if ((used < PORT_CNT) && !conflict) begin
          port_en[used[1:0]]       = 1'b1;
          port_req[used[1:0]].addr = addr[idx];
          port_req[used[1:0]].data = data[idx];
          accept[idx]              = 1'b1;
          used                     = used + 3'd1;
          any_grant                = 1'b1;
          next_head                = idx + HEAD_W'(1);
        end
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/deu_gpr_wb_arb.sv
// +--------------------------------------------------------------------------+
// | deu_gpr_wb_arb : 4-requester to 3-port GPR writeback arbiter.            |
// | DEU_WB_RR_EN selects round-robin priority (fixed req0-first otherwise).  |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef LA64_ARF_SEL
`define LA64_ARF_SEL 5
`endif
`ifndef LA64_DATA_WIDTH
`define LA64_DATA_WIDTH 64
`endif

module deu_gpr_wb_arb #(
  parameter int NREQ  = deu_pkg::NREQ,
  parameter int NPORT = deu_pkg::NPORT
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NREQ-1:0]                        req_valid,
  input  logic [NREQ-1:0][`LA64_ARF_SEL-1:0]     req_addr,
  input  logic [NREQ-1:0][`LA64_DATA_WIDTH-1:0]  req_data,
  output logic [NREQ-1:0]                        req_ready,
  output logic                                   we0,
  output logic                                   we1,
  output logic                                   we2,
  output logic [`LA64_ARF_SEL-1:0]               waddr0,
  output logic [`LA64_ARF_SEL-1:0]               waddr1,
  output logic [`LA64_ARF_SEL-1:0]               waddr2,
  output logic [`LA64_DATA_WIDTH-1:0]            wdata0,
  output logic [`LA64_DATA_WIDTH-1:0]            wdata1,
  output logic [`LA64_DATA_WIDTH-1:0]            wdata2
);
  import deu_pkg::*;

  localparam int AW = `LA64_ARF_SEL;
  localparam int DW = `LA64_DATA_WIDTH;
  localparam int OW = 1 + AW + DW;

  logic [HEAD_W-1:0]         head;
  logic [HEAD_W-1:0]         next_head;
  logic                      any_grant;
  logic [NREQ-1:0]           accept;
  logic [NPORT-1:0]          port_en;
  wb_req_t [NPORT-1:0]       port_req;
  logic [NPORT-1:0][OW-1:0]  out_q;

  deu_wb_prio_sel #(
    .NREQ   (NREQ),
    .NPORT  (NPORT),
    .HEAD_W (HEAD_W)
  ) u_sel (
    .head      (head),
    .valid     (req_valid),
    .addr      (req_addr),
    .data      (req_data),
    .accept    (accept),
    .port_en   (port_en),
    .port_req  (port_req),
    .any_grant (any_grant),
    .next_head (next_head)
  );

  // Nothing is accepted while reset is held; requesters re-present afterwards.
  assign req_ready = rst ? '0 : accept;

`ifdef DEU_WB_RR_EN
  dffe #(.W(HEAD_W)) u_head (
    .clk (clk),
    .rst (rst),
    .en  (any_grant),
    .d   (next_head),
    .q   (head)
  );
`else
  logic unused_rr;
  assign head      = '0;
  assign unused_rr = ^{any_grant, next_head};
`endif

  // Unused ports already carry all-zero payload from the selector.
  generate
    for (genvar p = 0; p < NPORT; p++) begin : g_port
      dff #(.W(OW)) u_out (
        .clk (clk),
        .rst (rst),
        .d   ({port_en[p], port_req[p]}),
        .q   (out_q[p])
      );
    end
  endgenerate

  assign we0    = out_q[0][OW-1];
  assign we1    = out_q[1][OW-1];
  assign we2    = out_q[2][OW-1];
  assign waddr0 = out_q[0][OW-2 -: AW];
  assign waddr1 = out_q[1][OW-2 -: AW];
  assign waddr2 = out_q[2][OW-2 -: AW];
  assign wdata0 = out_q[0][DW-1:0];
  assign wdata1 = out_q[1][DW-1:0];
  assign wdata2 = out_q[2][DW-1:0];
endmodule

`default_nettype wire

// File: tb/tb_deu_gpr_wb_arb.sv
// +--------------------------------------------------------------------------+
// | tb_deu_gpr_wb_arb : directed + random bench for deu_gpr_wb_arb           |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef LA64_ARF_SEL
`define LA64_ARF_SEL 5
`endif
`ifndef LA64_DATA_WIDTH
`define LA64_DATA_WIDTH 64
`endif

module tb_deu_gpr_wb_arb;
  localparam int AW = `LA64_ARF_SEL;
  localparam int DW = `LA64_DATA_WIDTH;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [3:0]            req_valid;
  logic [3:0][AW-1:0]    req_addr;
  logic [3:0][DW-1:0]    req_data;
  logic [3:0]            req_ready;
  logic                  we0, we1, we2;
  logic [AW-1:0]         waddr0, waddr1, waddr2;
  logic [DW-1:0]         wdata0, wdata1, wdata2;

  deu_gpr_wb_arb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready),
    .we0(we0), .we1(we1), .we2(we2),
    .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          m_head = 0;
  int          nh;
  logic [3:0]  exp_ready, last_ready, obs_ready;
  logic [2:0]  exp_we;
  logic [AW-1:0] exp_wa [3];
  logic [DW-1:0] exp_wd [3];
  int          grant_cnt [4];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: walk requesters from head, writes go to the next free port
  // unless the port budget is spent or the address was already taken.
  task automatic model();
    int granted[$];
    bit dup;
    int i;
    exp_ready = '0;
    exp_we    = '0;
    for (int p = 0; p < 3; p++) begin exp_wa[p] = '0; exp_wd[p] = '0; end
    nh = m_head;
    if (rst) begin
      nh = 0;
      return;
    end
    for (int k = 0; k < 4; k++) begin
      i = (m_head + k) % 4;
      if (!req_valid[i]) continue;
      if (req_addr[i] == '0) begin exp_ready[i] = 1'b1; continue; end
      if (granted.size() >= 3) continue;
      dup = 1'b0;
      foreach (granted[j]) if (req_addr[granted[j]] == req_addr[i]) dup = 1'b1;
      if (dup) continue;
      exp_ready[i] = 1'b1;
      exp_we[granted.size()] = 1'b1;
      exp_wa[granted.size()] = req_addr[i];
      exp_wd[granted.size()] = req_data[i];
      granted.push_back(i);
      grant_cnt[i]++;
`ifdef DEU_WB_RR_EN
      nh = (i + 1) % 4;
`endif
    end
`ifndef DEU_WB_RR_EN
    nh = 0;
`endif
  endtask

  task automatic cycle(string tag);
    model();
    @(negedge clk);
    obs_ready = req_ready;
    chk($sformatf("%s.ready", tag), req_ready, exp_ready);
    @(posedge clk);
    #1;
    m_head     = nh;
    last_ready = exp_ready;
    chk($sformatf("%s.we", tag), {we2, we1, we0}, exp_we);
    chk($sformatf("%s.waddr0", tag), waddr0, exp_wa[0]);
    chk($sformatf("%s.waddr1", tag), waddr1, exp_wa[1]);
    chk($sformatf("%s.waddr2", tag), waddr2, exp_wa[2]);
    chk($sformatf("%s.wdata0", tag), wdata0, exp_wd[0]);
    chk($sformatf("%s.wdata1", tag), wdata1, exp_wd[1]);
    chk($sformatf("%s.wdata2", tag), wdata2, exp_wd[2]);
    chk($sformatf("%s.nodup", tag),
        {63'd0, (we0 && we1 && waddr0 == waddr1) || (we0 && we2 && waddr0 == waddr2) ||
                (we1 && we2 && waddr1 == waddr2)}, 64'd0);
  endtask

  // A request still waiting keeps its payload; others may change freely.
  task automatic rand_inputs();
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && !last_ready[i]) continue;
      req_valid[i] = ($urandom_range(0, 3) != 0);
      req_addr[i]  = AW'($urandom_range(0, 7));
      req_data[i]  = {$urandom, $urandom};
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 4'b1111;
    req_addr   = '0;
    req_data   = '0;
    last_ready = '0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = AW'(i + 1);
      grant_cnt[i] = 0;
    end
    cycle("reset0");
    cycle("reset1");
    chk("reset.ready_const", obs_ready, 4'b0000);

    // All four valid with distinct addresses from head 0.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = AW'(i + 1);
      req_data[i] = {32'hDA7A_0000, 32'(i + 10)};
    end
    cycle("s037");
    chk("s037.ready_const", obs_ready, 4'b0111);
    chk("s037.waddr_const", {waddr2, waddr1, waddr0}, {AW'(3), AW'(2), AW'(1)});
    req_valid = 4'b1000;
    cycle("s037b");
`ifdef DEU_WB_RR_EN
    chk("s037b.req3_port0", waddr0, AW'(4));
`endif
    cycle("s037c");

    // Same-address pair.
    req_valid   = 4'b0011;
    req_addr[0] = AW'(5);
    req_addr[1] = AW'(5);
    cycle("s038a");
    chk("s038a.one_we", {we2, we1, we0}, 3'b001);
    req_valid = 4'b0010;
    cycle("s038b");
    chk("s038b.waddr0", waddr0, AW'(5));

    // Zero-address request is dropped without taking a port.
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) req_addr[i] = AW'(i + 1);
    req_addr[2] = '0;
    cycle("s039");
    chk("s039.ready2", {63'd0, obs_ready[2]}, 64'd1);
    chk("s039.three_we", {we2, we1, we0}, 3'b111);

    // Continuous distinct-address traffic for 8 cycles.
    for (int i = 0; i < 4; i++) begin
      req_addr[i]  = AW'(i + 1);
      grant_cnt[i] = 0;
    end
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) req_data[i] = {$urandom, $urandom};
      cycle("s040");
    end
`ifdef DEU_WB_RR_EN
    chk("s040.req3_granted", {63'd0, grant_cnt[3] >= 4}, 64'd1);
`else
    chk("s041.req3_starved", 64'(grant_cnt[3]), 64'd0);
`endif

    // Random traffic, with a reset dropped in mid-stream.
    for (int c = 0; c < 300; c++) begin
      rand_inputs();
      if (c == 150) begin
        rst = 1'b1;
        cycle("s042.rst");
        chk("s042.ready_const", obs_ready, 4'b0000);
        chk("s042.we_const", {we2, we1, we0}, 3'b000);
        rst        = 1'b0;
        last_ready = '0;
      end
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
